// File: rtl/output_port_arbiter_if.sv
// Bundle of the arbiter's requester-side and link-side signals.
//
// Handshake: req[i] is requester i's valid and grant[i] its ready. A flit
// moves from requester i to the output register in any cycle where
// req[i] && grant[i]. The requester must hold req[i] and its flit_in slice
// stable until that cycle and may drop or advance them in the next cycle.
// grant is combinational from req, so a requester must not make req depend
// on grant within the same cycle. stall = req & ~grant is the complement view
// of the same handshake. credit_in is a one-cycle pulse with no backpressure.
interface output_port_arbiter_if #(
  parameter int NUM_REQ   = 7,
  parameter int FLIT_SIZE = 82,
  parameter int CREDIT_W  = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*FLIT_SIZE-1:0] flit_in;
  logic                         credit_in;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           stall;
  logic [FLIT_SIZE-1:0]         out_flit;
  logic                         out_valid;
  logic [CREDIT_W-1:0]          credits;
  logic                         credit_ovf;

  // Requesters, credit source and link consumer.
  modport master (
    output req, flit_in, credit_in,
    input  grant, stall, out_flit, out_valid, credits, credit_ovf
  );

  // The arbiter itself.
  modport slave (
    input  req, flit_in, credit_in,
    output grant, stall, out_flit, out_valid, credits, credit_ovf
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin allocator for one router output port. Grants at most one
// requester per cycle (combinationally), registers the winning flit onto the
// output link and tracks downstream credits.
// Build option: define OUT_ARB_CREDIT_EN to enable the credit counter, credit
// gating of grants and the sticky credit_ovf flag. Without it the link is
// always allowed to send, credits reads CREDIT_INIT and credit_ovf reads 0.
module output_port_arbiter #(
  parameter int NUM_REQ     = 7,
  parameter int FLIT_SIZE   = 82,
  parameter int CREDIT_INIT = 5,
  parameter int CREDIT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output_port_arbiter_if.slave  bus
);
  localparam int PRIO_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_INIT);

  logic [PRIO_W-1:0]    prio_q, prio_d;
  logic [PRIO_W-1:0]    grant_idx;
  logic                 grant_vld;
  logic [NUM_REQ-1:0]   grant_vec;
  logic [PRIO_W:0]      scan_idx;
  logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
  logic                 out_valid_q, out_valid_d;
  logic                 can_send;

  // Scan req starting at prio, wrapping, and pick the first set bit.
  // Grants are suppressed while reset is held or no credit is left.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, prio_q} + (PRIO_W+1)'(k);
      if (scan_idx >= (PRIO_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PRIO_W+1)'(NUM_REQ);
      end
      if (!grant_vld && bus.req[scan_idx[PRIO_W-1:0]]) begin
        grant_idx = scan_idx[PRIO_W-1:0];
        grant_vld = 1'b1;
      end
    end
    if (!rst || !can_send) begin
      grant_vld = 1'b0;
    end
    grant_vec            = '0;
    grant_vec[grant_idx] = grant_vld;
  end

  assign bus.grant = grant_vec;
  assign bus.stall = rst ? (bus.req & ~grant_vec) : '0;

  // Next pointer and output register contents from the current grant.
  always_comb begin
    prio_d      = prio_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    if (grant_vld) begin
      prio_d      = (grant_idx == PRIO_W'(NUM_REQ-1)) ? '0 : grant_idx + PRIO_W'(1);
      out_flit_d  = bus.flit_in[int'(grant_idx)*FLIT_SIZE +: FLIT_SIZE];
      out_valid_d = 1'b1;
    end
  end

  // Priority pointer and output link register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_flit  = out_flit_q;
  assign bus.out_valid = out_valid_q;

`ifdef OUT_ARB_CREDIT_EN
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                credit_ovf_q, credit_ovf_d;

  assign can_send = (credits_q != '0);

  // A grant spends one credit and a returned credit adds one; both together
  // cancel. A return at full count is a downstream protocol error.
  always_comb begin
    credits_d    = credits_q;
    credit_ovf_d = credit_ovf_q;
    if (grant_vld && !bus.credit_in) begin
      credits_d = credits_q - CREDIT_W'(1);
    end else if (!grant_vld && bus.credit_in) begin
      if (credits_q == CREDIT_FULL) begin
        credit_ovf_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_W'(1);
      end
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q    <= CREDIT_FULL;
      credit_ovf_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_ovf_q <= credit_ovf_d;
    end
  end

  assign bus.credits    = credits_q;
  assign bus.credit_ovf = credit_ovf_q;
`else
  logic unused_credit_in;

  assign can_send         = 1'b1;
  assign unused_credit_in = bus.credit_in;
  assign bus.credits      = CREDIT_FULL;
  assign bus.credit_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the round-robin and credit rules.
`timescale 1ns/1ps
module tb_output_port_arbiter;
  localparam int N  = 7;
  localparam int FW = 82;
  localparam int CI = 5;
  localparam int CW = 4;
`ifdef OUT_ARB_CREDIT_EN
  localparam bit CREDIT_EN = 1'b1;
`else
  localparam bit CREDIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  output_port_arbiter_if #(.NUM_REQ(N), .FLIT_SIZE(FW), .CREDIT_W(CW)) bus ();

  output_port_arbiter #(
    .NUM_REQ(N), .FLIT_SIZE(FW), .CREDIT_INIT(CI), .CREDIT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int            m_prio;
  int            m_credits;
  bit            m_ovf;
  logic [FW-1:0] m_flit;
  bit            m_valid;
  logic [FW-1:0] flits [N];
  logic [FW-1:0] exp_q [$];

  function automatic logic [FW-1:0] rand_flit();
    logic [FW-1:0] f;
    f[31:0]    = $urandom;
    f[63:32]   = $urandom;
    f[FW-1:64] = (FW-64)'($urandom);
    f[FW-1]    = 1'b1;
    return f;
  endfunction

  // Winner under the current model state, -1 if nobody is granted.
  function automatic int model_grant_idx(input logic [N-1:0] r);
    if (!rst) return -1;
    if (CREDIT_EN && m_credits == 0) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_prio + k) % N]) return (m_prio + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_credits();
    return CREDIT_EN ? CW'(m_credits) : CW'(CI);
  endfunction

  task automatic model_reset();
    m_prio    = 0;
    m_credits = CI;
    m_ovf     = 1'b0;
    m_flit    = '0;
    m_valid   = 1'b0;
    exp_q.delete();
  endtask

  // Driver: apply requests, credit pulse and current flits.
  task automatic set_inputs(input logic [N-1:0] r, input logic cr);
    bus.req       = r;
    bus.credit_in = cr;
    for (int i = 0; i < N; i++) bus.flit_in[i*FW +: FW] = flits[i];
  endtask

  // Advance one clock edge and step the model; returns the model's winner.
  task automatic tick(output int g);
    logic cr;
    g  = model_grant_idx(bus.req);
    cr = bus.credit_in;
    @(posedge clk);
    if (g >= 0) begin
      m_flit  = flits[g];
      m_valid = 1'b1;
      exp_q.push_back(flits[g]);
      m_prio  = (g + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    if (CREDIT_EN) begin
      if (g >= 0 && !cr) m_credits--;
      else if (g < 0 && cr) begin
        if (m_credits == CI) m_ovf = 1'b1;
        else m_credits++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_inputs('0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) flits[i] = rand_flit();
    set_inputs('1, 1'b0);
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (bus.grant !== '0) begin
      tests_failed++; $display("FAIL reset_grant: got %b want 0", bus.grant);
    end
    tests_run++;
    if (bus.stall !== '0) begin
      tests_failed++; $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_flit !== '0) begin
      tests_failed++; $display("FAIL reset_out: got valid %b flit %h want 0/0", bus.out_valid, bus.out_flit);
    end
    tests_run++;
    if (bus.credits !== CW'(CI) || bus.credit_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_credits: got %0d ovf %b want %0d ovf 0", bus.credits, bus.credit_ovf, CI);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    int g;
    f = '0;
    f[FW-1] = 1'b1;
    f[7:0]  = 8'hAB;
    flits[1] = f;
    set_inputs(7'b0000010, 1'b0);
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 7'b0000010 || bus.stall !== 7'b0) begin
      tests_failed++; $display("FAIL single_grant: got %b stall %b want 0000010 stall 0", bus.grant, bus.stall);
    end
    tick(g);
    set_inputs('0, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_flit !== f) begin
      tests_failed++; $display("FAIL single_out: got valid %b flit %h want 1 %h", bus.out_valid, bus.out_flit, f);
    end
    tests_run++;
    if (bus.credits !== (CREDIT_EN ? CW'(4) : CW'(CI))) begin
      tests_failed++; $display("FAIL single_credits: got %0d want %0d", bus.credits, CREDIT_EN ? 4 : CI);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 3*N + 1; c++) begin
      set_inputs('1, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus.grant !== onehot(c % N)) begin
        tests_failed++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, onehot(c % N));
      end
      for (int i = 0; i < N; i++) if (bus.grant[i]) cnt[i]++;
      tick(g);
      if (g >= 0) flits[g] = rand_flit();
      tests_run++;
      if (bus.credits !== CW'(CI) || bus.credit_ovf !== 1'b0) begin
        tests_failed++; $display("FAIL rr_credits c%0d: got %0d ovf %b want %0d ovf 0", c, bus.credits, bus.credit_ovf, CI);
      end
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== m_flit) begin
        tests_failed++; $display("FAIL rr_out c%0d: got %b %h want 1 %h", c, bus.out_valid, bus.out_flit, m_flit);
      end
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (cnt[i] != ((i == 0) ? 4 : 3)) begin
        tests_failed++; $display("FAIL rr_fair req%0d: got %0d grants want %0d", i, cnt[i], (i == 0) ? 4 : 3);
      end
    end
    set_inputs('0, 1'b0);
  endtask

  task automatic test_credit_exhaust();
    int g;
    logic [N-1:0] eg;
    int cred_tab [8] = '{4, 3, 2, 1, 0, 0, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_inputs(7'b0001000, c == 6);
      @(negedge clk);
      eg = (!CREDIT_EN || c < 5 || c == 7) ? 7'b0001000 : 7'b0;
      tests_run++;
      if (bus.grant !== eg || bus.stall !== (7'b0001000 & ~eg)) begin
        tests_failed++; $display("FAIL exhaust_grant c%0d: got %b stall %b want %b", c, bus.grant, bus.stall, eg);
      end
      tick(g);
      if (g >= 0) flits[3] = rand_flit();
      tests_run++;
      if (bus.credits !== (CREDIT_EN ? CW'(cred_tab[c]) : CW'(CI))) begin
        tests_failed++; $display("FAIL exhaust_credits c%0d: got %0d want %0d", c, bus.credits, CREDIT_EN ? cred_tab[c] : CI);
      end
    end
    set_inputs('0, 1'b0);
  endtask

  task automatic test_simul_and_ovf();
    int g;
    int r_tab   [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    int cr_tab  [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int cred_tab[8] = '{4, 3, 3, 4, 5, 5, 5, 4};
    int ovf_tab [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_inputs((r_tab[c] != 0) ? 7'b0000001 : 7'b0, cr_tab[c] != 0);
      @(negedge clk);
      tests_run++;
      if (bus.grant !== ((r_tab[c] != 0) ? 7'b0000001 : 7'b0)) begin
        tests_failed++; $display("FAIL simul_grant c%0d: got %b want req %0d", c, bus.grant, r_tab[c]);
      end
      tick(g);
      if (g >= 0) flits[0] = rand_flit();
      tests_run++;
      if (bus.credits !== (CREDIT_EN ? CW'(cred_tab[c]) : CW'(CI)) ||
          bus.credit_ovf !== (CREDIT_EN ? (ovf_tab[c] != 0) : 1'b0)) begin
        tests_failed++; $display("FAIL simul_credits c%0d: got %0d ovf %b want %0d ovf %0d", c, bus.credits,
                                 bus.credit_ovf, CREDIT_EN ? cred_tab[c] : CI, CREDIT_EN ? ovf_tab[c] : 0);
      end
    end
    set_inputs('0, 1'b0);
  endtask

  task automatic test_reset_midop();
    int g;
    do_reset();
    set_inputs('1, 1'b0);
    @(negedge clk);
    tick(g);
    flits[0] = rand_flit();
    set_inputs('1, 1'b0);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (bus.grant !== '0 || bus.stall !== '0 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_async: got grant %b stall %b valid %b want 0/0/0", bus.grant, bus.stall, bus.out_valid);
    end
    tests_run++;
    if (bus.credits !== CW'(CI) || bus.credit_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_credits: got %0d ovf %b want %0d ovf 0", bus.credits, bus.credit_ovf, CI);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_lost: got valid %b want 0", bus.out_valid);
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 7'b0000001) begin
      tests_failed++; $display("FAIL midrst_prio: got %b want 0000001", bus.grant);
    end
    set_inputs('0, 1'b0);
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] r;
    logic [N-1:0] eg;
    logic [FW-1:0] ef;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i] && $urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
          flits[i] = rand_flit();
        end
      end
      set_inputs(r, $urandom_range(0, 9) < 4);
      @(negedge clk);
      eg = onehot(model_grant_idx(r));
      tests_run++;
      if (bus.grant !== eg || bus.stall !== (r & ~eg)) begin
        tests_failed++; $display("FAIL rand_grant c%0d: got %b stall %b want %b stall %b", c, bus.grant, bus.stall, eg, r & ~eg);
      end
      tick(g);
      if (g >= 0) begin
        r[g] = ($urandom_range(0, 1) == 1);
        if (r[g]) flits[g] = rand_flit();
      end
      tests_run++;
      if (bus.out_valid !== m_valid) begin
        tests_failed++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.out_valid, m_valid);
      end
      if (bus.out_valid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rand_sb c%0d: got flit %h want none", c, bus.out_flit);
        end else begin
          ef = exp_q.pop_front();
          if (bus.out_flit !== ef) begin
            tests_failed++; $display("FAIL rand_flit c%0d: got %h want %h", c, bus.out_flit, ef);
          end
        end
      end
      tests_run++;
      if (bus.credits !== exp_credits() || bus.credit_ovf !== (CREDIT_EN ? m_ovf : 1'b0)) begin
        tests_failed++; $display("FAIL rand_credits c%0d: got %0d ovf %b want %0d ovf %b", c, bus.credits,
                                 bus.credit_ovf, exp_credits(), CREDIT_EN ? m_ovf : 1'b0);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL rand_drain: got %0d flits left want 0", exp_q.size());
    end
    set_inputs('0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_exhaust();
    test_simul_and_ovf();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
